// File: rtl/lsu_unit.sv
// lsu_unit: load/store unit between the core and a req/gnt/rvalid data
// memory; lane-aligns stores, extends loads, splits word-crossing accesses.
module lsu_unit #(
  parameter int DATA_W           = 32,
  parameter int ADDR_W           = 32,
  parameter int ALLOW_MISALIGNED = 1,
  parameter int TIMEOUT          = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_err
);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ1, S_WAIT1, S_REQ2, S_WAIT2, S_RESP
  } state_t;

  function automatic logic [NB-1:0] f_bm(input logic [4:0] n);
    logic [NB-1:0] m;
    for (int i = 0; i < NB; i++) m[i] = (5'(i) < n);
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] f_bits(input logic [NB-1:0] m);
    logic [DATA_W-1:0] b;
    for (int i = 0; i < NB; i++) b[8*i +: 8] = {8{m[i]}};
    return b;
  endfunction

  state_t            r_state, w_nxt;
  logic [ADDR_W-1:0] r_base;
  logic [OW-1:0]     r_off;
  logic [1:0]        r_size;
  logic              r_we, r_uns, r_split, r_bad, r_err;
  logic [DATA_W-1:0] r_wdata, r_lo, r_rdata;
  logic [CW-1:0]     r_cnt;

  logic [OW-1:0]       w_off_in;
  logic [4:0]          w_nb_in, w_end_in, w_nb;
  logic                w_split_in, w_mis_in, w_ill_in, w_bad_in;
  logic [2*NB-1:0]     w_sbe;
  logic [2*DATA_W-1:0] w_swd, w_cat;
  logic [DATA_W-1:0]   w_asm, w_ext;
  logic                w_sb, w_tmo, w_err_n, w_b1, w_b2;

  assign w_off_in   = req_addr[OW-1:0];
  assign w_nb_in    = 5'd1 << req_funct3[1:0];
  assign w_end_in   = 5'(w_off_in) + w_nb_in;
  assign w_split_in = w_end_in > 5'(NB);
  assign w_mis_in   = |(5'(w_off_in) & (w_nb_in - 5'd1));
  assign w_ill_in   = (req_funct3[1:0] == 2'd3) && (DATA_W == 32);
  assign w_bad_in   = w_ill_in | (w_mis_in & (ALLOW_MISALIGNED == 0));

  // Both beats come from one double-width shift; the upper half is beat 2.
  assign w_nb  = 5'd1 << r_size;
  assign w_sbe = {{NB{1'b0}}, f_bm(w_nb)} << r_off;
  assign w_swd = {{DATA_W{1'b0}}, r_wdata} << {r_off, 3'b000};

  assign w_cat = r_split ? {mem_rdata, r_lo} : {{DATA_W{1'b0}}, mem_rdata};
  assign w_asm = DATA_W'(w_cat >> {r_off, 3'b000});

  always_comb begin
    case (r_size)
      2'd0:    w_sb = w_asm[7];
      2'd1:    w_sb = w_asm[15];
      2'd2:    w_sb = w_asm[31];
      default: w_sb = w_asm[DATA_W-1];
    endcase
    w_sb  = w_sb & ~r_uns;
    w_ext = '0;
    for (int i = 0; i < NB; i++)
      w_ext[8*i +: 8] = (5'(i) < w_nb) ? w_asm[8*i +: 8] : {8{w_sb}};
  end

  assign w_tmo = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    w_nxt   = r_state;
    w_err_n = 1'b0;
    unique case (r_state)
      S_IDLE: if (req_valid) w_nxt = S_REQ1;
      S_REQ1: begin
        if (r_bad) begin
          w_nxt   = S_RESP;
          w_err_n = 1'b1;
        end else if (mem_gnt) begin
          w_nxt = S_WAIT1;
        end
      end
      S_WAIT1: begin
        if (mem_rvalid) begin
          if (mem_err) begin
            w_nxt   = S_RESP;
            w_err_n = 1'b1;
          end else begin
            w_nxt = r_split ? S_REQ2 : S_RESP;
          end
        end else if (w_tmo) begin
          w_nxt   = S_RESP;
          w_err_n = 1'b1;
        end
      end
      S_REQ2: if (mem_gnt) w_nxt = S_WAIT2;
      S_WAIT2: begin
        if (mem_rvalid) begin
          w_nxt   = S_RESP;
          w_err_n = mem_err;
        end else if (w_tmo) begin
          w_nxt   = S_RESP;
          w_err_n = 1'b1;
        end
      end
      S_RESP:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_off   <= '0;
      r_size  <= '0;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_split <= 1'b0;
      r_bad   <= 1'b0;
      r_err   <= 1'b0;
      r_wdata <= '0;
      r_lo    <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state == S_IDLE && req_valid) begin
        r_base  <= {req_addr[ADDR_W-1:OW], {OW{1'b0}}};
        r_off   <= w_off_in;
        r_size  <= req_funct3[1:0];
        r_we    <= req_we;
        r_uns   <= req_funct3[2];
        r_split <= w_split_in;
        r_bad   <= w_bad_in;
        r_wdata <= req_we ? (req_wdata & f_bits(f_bm(w_nb_in))) : '0;
      end
      if ((r_state == S_WAIT1 || r_state == S_WAIT2) && !mem_rvalid)
        r_cnt <= r_cnt + CW'(1);
      else
        r_cnt <= '0;
      if (r_state == S_WAIT1 && mem_rvalid) r_lo <= mem_rdata;
      if (w_nxt == S_RESP) begin
        r_err   <= w_err_n;
        r_rdata <= (w_err_n | r_we) ? '0 : w_ext;
      end
    end
  end

  assign w_b1 = (r_state == S_REQ1) & ~r_bad;
  assign w_b2 = (r_state == S_REQ2);

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_err   = rsp_valid & r_err;
  assign rsp_rdata = r_rdata;
  assign stall     = req_valid & ~rsp_valid;
  assign mem_req   = w_b1 | w_b2;
  assign mem_we    = mem_req & r_we;
  assign mem_addr  = w_b2 ? r_base + ADDR_W'(NB) : r_base;
  assign mem_be    = w_b1 ? w_sbe[NB-1:0] :
                     w_b2 ? w_sbe[2*NB-1:NB] : '0;
  assign mem_wdata = w_b1 ? w_swd[DATA_W-1:0] :
                     w_b2 ? w_swd[2*DATA_W-1:DATA_W] : '0;
endmodule

// File: tb/tb_lsu_unit.sv
// tb_lsu_unit: scoreboard bench for lsu_unit; one instance with splitting
// and a short timeout, one with misaligned accesses rejected.
module tb_lsu_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, stall;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic        b_req_valid, b_req_ready, b_req_we;
  logic [2:0]  b_req_funct3;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_rsp_valid, b_rsp_err, b_stall;
  logic [31:0] b_rsp_rdata;
  logic        b_mem_req, b_mem_we;
  logic [31:0] b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_be;
  logic        b_mem_gnt = 1'b0;
  logic        b_mem_rvalid = 1'b0;
  logic [31:0] b_mem_rdata = '0;
  logic        b_mem_err = 1'b0;

  always #5 clk = ~clk;

  lsu_unit #(
    .DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGNED(1), .TIMEOUT(4)
  ) u_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_err(mem_err)
  );

  lsu_unit #(
    .DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGNED(0), .TIMEOUT(255)
  ) u_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_funct3(b_req_funct3),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .stall(b_stall),
    .mem_req(b_mem_req), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_be(b_mem_be),
    .mem_wdata(b_mem_wdata), .mem_gnt(b_mem_gnt),
    .mem_rvalid(b_mem_rvalid), .mem_rdata(b_mem_rdata),
    .mem_err(b_mem_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        we;
  } beat_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
  } rsp_t;

  beat_t q_beat[$];
  rsp_t  q_rsp[$];
  rsp_t  q_rsp_b[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_rd[2];
  logic        m_err[2];
  int          m_gdly;
  bit          m_norv;
  int          m_beat;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic setmem(input logic [31:0] r0, input logic [31:0] r1,
                        input logic e0, input logic e1,
                        input int gd, input bit norv);
    m_rd[0] = r0;
    m_rd[1] = r1;
    m_err[0] = e0;
    m_err[1] = e1;
    m_gdly = gd;
    m_norv = norv;
  endtask

  task automatic exp_beat(input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd, input logic we);
    beat_t e;
    e.addr = a;
    e.be = be;
    e.wd = wd;
    e.we = we;
    q_beat.push_back(e);
  endtask

  task automatic exp_rsp(input logic [31:0] rd, input logic err,
                         input int lat);
    rsp_t r;
    r.rd = rd;
    r.err = err;
    r.lat = lat;
    q_rsp.push_back(r);
  endtask

  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    bit done;
    @(negedge clk);
    m_beat = 0;
    req_we = we;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = wd;
    req_valid = 1'b1;
    done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        done = 1;
        break;
      end
    end
    if (!done) chk("rsp_timeout", rsp_valid, 1);
    req_valid = 1'b0;
  endtask

  // Memory model: grant after m_gdly request cycles, answer next cycle.
  initial begin
    int  w;
    int  pi;
    bit  pend;
    w = 0;
    pi = 0;
    pend = 0;
    mem_gnt = 0;
    mem_rvalid = 0;
    mem_rdata = '0;
    mem_err = 0;
    forever begin
      @(negedge clk);
      mem_gnt = 0;
      mem_rvalid = 0;
      mem_rdata = '0;
      mem_err = 0;
      if (reset) begin
        pend = 0;
        w = 0;
      end else begin
        if (pend) begin
          mem_rvalid = 1;
          mem_rdata = m_rd[pi];
          mem_err = m_err[pi];
          pend = 0;
        end
        if (mem_req) begin
          if (w < m_gdly) begin
            w++;
          end else begin
            mem_gnt = 1;
            w = 0;
            pi = (m_beat > 1) ? 1 : m_beat;
            m_beat++;
            pend = !m_norv;
          end
        end
      end
    end
  end

  // Monitor: checks bus beats and responses against the queues.
  initial begin
    int    cyc;
    int    acc;
    int    bacc;
    beat_t e;
    rsp_t  r;
    cyc = 0;
    acc = 0;
    bacc = 0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (!reset) begin
        if (req_valid && req_ready) acc = cyc;
        if (b_req_valid && b_req_ready) bacc = cyc;
        if (mem_req) begin
          if (q_beat.size() == 0) begin
            chk("unexp_mem_req", mem_req, 0);
          end else begin
            e = q_beat[0];
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_be", mem_be, e.be);
            chk("mem_we", mem_we, e.we);
            chk("stall_busy", stall, 1);
            if (e.we) chk("mem_wdata", mem_wdata, e.wd);
            if (mem_gnt) void'(q_beat.pop_front());
            else chk("ready_in_req", req_ready, 0);
          end
        end
        if (rsp_valid) begin
          if (q_rsp.size() == 0) begin
            chk("unexp_rsp", rsp_valid, 0);
          end else begin
            r = q_rsp.pop_front();
            chk("rsp_rdata", rsp_rdata, r.rd);
            chk("rsp_err", rsp_err, r.err);
            chk("rsp_lat", cyc - acc, r.lat);
            chk("stall_rsp", stall, 0);
          end
        end
        if (b_mem_req) chk("b_mem_req", b_mem_req, 0);
        if (b_rsp_valid) begin
          if (q_rsp_b.size() == 0) begin
            chk("b_unexp_rsp", b_rsp_valid, 0);
          end else begin
            r = q_rsp_b.pop_front();
            chk("b_rsp_rdata", b_rsp_rdata, r.rd);
            chk("b_rsp_err", b_rsp_err, r.err);
            chk("b_rsp_lat", cyc - bacc, r.lat);
          end
        end
      end
    end
  end

  initial begin
    bit   done;
    rsp_t rb;
    reset = 1'b1;
    req_valid = 0;
    req_we = 0;
    req_funct3 = '0;
    req_addr = '0;
    req_wdata = '0;
    b_req_valid = 0;
    b_req_we = 0;
    b_req_funct3 = '0;
    b_req_addr = '0;
    b_req_wdata = '0;
    m_beat = 0;
    setmem(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_wdata", mem_wdata, 0);
    reset = 1'b0;

    setmem(32'hDEADBEEF, 0, 0, 0, 0, 0);
    exp_beat(32'h104, 4'hF, 0, 0);
    exp_rsp(32'hDEADBEEF, 0, 3);
    issue(0, 3'd2, 32'h104, 0);

    setmem(32'h80123456, 0, 0, 0, 0, 0);
    exp_beat(32'h100, 4'h8, 0, 0);
    exp_rsp(32'hFFFFFF80, 0, 3);
    issue(0, 3'd0, 32'h103, 0);

    exp_beat(32'h100, 4'h8, 0, 0);
    exp_rsp(32'h00000080, 0, 3);
    issue(0, 3'd4, 32'h103, 0);

    setmem(0, 0, 0, 0, 0, 0);
    exp_beat(32'h100, 4'h4, 32'h00A50000, 1);
    exp_rsp(0, 0, 3);
    issue(1, 3'd0, 32'h102, 32'h000000A5);

    exp_beat(32'h204, 4'hC, 32'h33440000, 1);
    exp_beat(32'h208, 4'h3, 32'h00001122, 1);
    exp_rsp(0, 0, 5);
    issue(1, 3'd2, 32'h206, 32'h11223344);

    setmem(32'hAB000000, 32'h000000CD, 0, 0, 0, 0);
    exp_beat(32'h100, 4'h8, 0, 0);
    exp_beat(32'h104, 4'h1, 0, 0);
    exp_rsp(32'hFFFFCDAB, 0, 5);
    issue(0, 3'd1, 32'h103, 0);

    setmem(32'h80017777, 0, 0, 0, 0, 0);
    exp_beat(32'h000, 4'hC, 0, 0);
    exp_rsp(32'h00008001, 0, 3);
    issue(0, 3'd5, 32'h002, 0);

    setmem(32'h332211FF, 32'h00000044, 0, 0, 0, 0);
    exp_beat(32'h304, 4'hE, 0, 0);
    exp_beat(32'h308, 4'h1, 0, 0);
    exp_rsp(32'h44332211, 0, 5);
    issue(0, 3'd2, 32'h305, 0);

    setmem(32'h12345678, 32'h9ABCDEF0, 1, 0, 0, 0);
    exp_beat(32'h400, 4'hC, 0, 0);
    exp_rsp(0, 1, 3);
    issue(0, 3'd2, 32'h402, 0);

    setmem(0, 0, 0, 1, 0, 0);
    exp_beat(32'h500, 4'h8, 32'hEF000000, 1);
    exp_beat(32'h504, 4'h1, 32'h000000BE, 1);
    exp_rsp(0, 1, 5);
    issue(1, 3'd1, 32'h503, 32'h0000BEEF);

    setmem(0, 0, 0, 0, 0, 1);
    exp_beat(32'h600, 4'hF, 0, 0);
    exp_rsp(0, 1, 6);
    issue(0, 3'd2, 32'h600, 0);

    setmem(0, 0, 0, 0, 5, 0);
    exp_beat(32'h700, 4'hF, 32'hCAFEF00D, 1);
    exp_rsp(0, 0, 8);
    issue(1, 3'd2, 32'h700, 32'hCAFEF00D);

    setmem(0, 0, 0, 0, 0, 0);
    exp_rsp(0, 1, 2);
    issue(0, 3'd3, 32'h010, 0);

    rb.rd = 0;
    rb.err = 1;
    rb.lat = 2;
    q_rsp_b.push_back(rb);
    @(negedge clk);
    b_req_we = 0;
    b_req_funct3 = 3'd1;
    b_req_addr = 32'h7;
    b_req_valid = 1;
    done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b_rsp_valid) begin
        done = 1;
        break;
      end
    end
    if (!done) chk("b_rsp_timeout", b_rsp_valid, 1);
    b_req_valid = 0;

    setmem(0, 0, 0, 0, 0, 1);
    exp_beat(32'h800, 4'hF, 0, 0);
    @(negedge clk);
    m_beat = 0;
    req_we = 0;
    req_funct3 = 3'd2;
    req_addr = 32'h800;
    req_valid = 1;
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    req_valid = 0;
    #1;
    chk("rstw_mem_req", mem_req, 0);
    chk("rstw_rsp_valid", rsp_valid, 0);
    chk("rstw_be", mem_be, 0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rstw_ready", req_ready, 1);
    repeat (8) @(negedge clk);

    setmem(32'h0BADF00D, 0, 0, 0, 0, 0);
    exp_beat(32'h104, 4'hF, 0, 0);
    exp_rsp(32'h0BADF00D, 0, 3);
    issue(0, 3'd2, 32'h104, 0);

    repeat (5) @(negedge clk);
    chk("beats_left", q_beat.size(), 0);
    chk("rsps_left", q_rsp.size(), 0);
    chk("b_rsps_left", q_rsp_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lsu_unit.md
Name: lsu_unit

Overview:
- Parametrised load/store unit between the core datapath and a handshaked data memory. Replaces the combinational store and load-extension muxing.
- Accepts one load/store per request and drives a request/grant/response memory port with byte enables.
- Sign- or zero-extends load data. Splits misaligned accesses into two beats when enabled.
- Holds the core via `stall` until the access completes.

Parameters:
- DATA_W, 32, memory/data word width; legal values 32 or 64.
- ADDR_W, 32, byte address width.
- ALLOW_MISALIGNED, 1, 1 = split accesses that cross a word boundary; 0 = error response.
- TIMEOUT, 255, max cycles waiting for `mem_rvalid` per beat before error; 0 disables.

Ports:
- `clk` in 1: global clock.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: core presents a load/store; held until `rsp_valid`.
- `req_ready` out 1: unit can accept.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: [1:0] size (0=B, 1=H, 2=W, 3=D); [2] unsigned load.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in DATA_W: store data, right-aligned.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out DATA_W: extended load data; 0 for stores and errors.
- `rsp_err` out 1: misaligned (when disallowed), illegal size, bus error or timeout; valid with `rsp_valid`.
- `stall` out 1: equals `req_valid & ~rsp_valid`.
- `mem_req` out 1: memory request; held until grant.
- `mem_we` out 1: write.
- `mem_addr` out ADDR_W: word-aligned address, low log2(DATA_W/8) bits zero.
- `mem_be` out DATA_W/8: byte enables.
- `mem_wdata` out DATA_W: lane-aligned write data.
- `mem_gnt` in 1: request accepted this cycle.
- `mem_rvalid` in 1: read data / write ack valid.
- `mem_rdata` in DATA_W: read data.
- `mem_err` in 1: bus error; qualified by `mem_rvalid`.

Behaviour:
- Reset (async): state IDLE, counters 0. `mem_req`, `rsp_valid` and `rsp_err` go to 0 immediately; `rsp_rdata`, `mem_be` and `mem_wdata` go to 0; `req_ready` = 1.
- FSM states: IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP.
- IDLE:
  - `req_ready` = 1. On `req_valid`, capture addr, size, we, wdata and unsigned flag.
  - Compute offset = addr mod NB (NB = DATA_W/8) and nbytes = 1 << size.
  - Illegal (size 3 with DATA_W=32), or misaligned with ALLOW_MISALIGNED=0: go to RESP with err.
  - Otherwise go to REQ1.
- REQ1/REQ2:
  - `mem_req` = 1; hold `mem_addr`, `mem_be`, `mem_wdata` and `mem_we` stable until `mem_gnt`.
  - On grant go to WAIT1/WAIT2.
- WAIT1:
  - On `mem_rvalid` with `mem_err`: go to RESP with err; second beat is not issued.
  - Otherwise, if split, latch beat data and go to REQ2 at address base+NB. Else go to RESP.
- WAIT2: on `mem_rvalid`, go to RESP; err = `mem_err`.
- Timeout: per-beat counter runs in WAITx. When it reaches TIMEOUT, go to RESP with err.
- Split condition: offset + nbytes > NB.
  - Beat 1 covers bytes offset..NB-1.
  - Beat 2 covers bytes 0..offset+nbytes-NB-1 at the next word.
- Stores:
  - Beat 1: `mem_wdata` = wdata << 8·offset; `mem_be` = ((1<<nbytes)-1) << offset, truncated to NB bits.
  - Beat 2: remaining upper bytes at lane 0 with matching low `mem_be`.
- Loads:
  - `mem_be` is driven as for stores.
  - Assemble nbytes bytes (beat 1 bytes from offset, then beat 2 bytes), then extend. Sign-extend from the top assembled bit unless the unsigned flag is set.
  - Size W on DATA_W=32 ignores the unsigned flag.
- RESP: `rsp_valid` = 1 for exactly one cycle; `req_ready` = 0; then IDLE. The next request can be accepted in the following cycle.
- Latency: aligned access with zero-wait memory (`gnt` in REQ1, `rvalid` the next cycle): `rsp_valid` 3 cycles after acceptance. A split access adds 2 cycles.
- `req_valid` deassertion mid-operation is not supported; the core holds it while `stall` = 1.
- `mem_rvalid` outside WAITx is ignored.

Test Plan:
- Aligned LW: addr 0x104, mem_rdata 0xDEADBEEF, immediate gnt → `mem_addr` 0x104, `mem_be` 0xF, `rsp_rdata` 0xDEADBEEF, `rsp_valid` 3 cycles after accept, `stall` high until then.
- LB/LBU: addr 0x103, mem_rdata 0x80123456 → LB gives 0xFFFFFF80, LBU gives 0x00000080. SB of 0x000000A5 at 0x102 → `mem_be` 0x4, `mem_wdata` 0x00A50000.
- Misaligned SW, ALLOW_MISALIGNED=1: SW 0x11223344 at 0x206 → beat 1 addr 0x204, be 0xC, wdata 0x33440000; beat 2 addr 0x208, be 0x3, wdata 0x00001122; one `rsp_valid`, err 0.
- Misaligned LH, ALLOW_MISALIGNED=0: LH at 0x7 → no `mem_req`, `rsp_valid` with `rsp_err` = 1 and `rsp_rdata` 0, 2 cycles after accept.
- Error and timeout: `mem_err` on beat 1 of a split load → no beat 2, `rsp_err` = 1. TIMEOUT=4 with no `rvalid` → `rsp_err` = 1 after 4 WAIT cycles.
- Reset and backpressure: `mem_gnt` held low for 5 cycles → address and data stable, `req_ready` = 0. Assert `reset` in WAIT1 → `mem_req` and `rsp_valid` drop immediately, `req_ready` = 1 after release, no stale response.
